// File: rtl/tc_accum_pkg.sv
// Shared types and helpers for the pulse accumulator: FSM encoding, lane unpack,
// sign extension and accumulator-width legality.
package tc_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DUMP    = 2'd3
  } tc_state_e;

  localparam int X0_MSB  = 31;
  localparam int X0Z_MSB = 15;
  localparam int SEXT_W  = 64;

  function automatic logic [15:0] lane_x0(input logic [31:0] d);
    return d[X0_MSB -: 16];
  endfunction

  function automatic logic [15:0] lane_x0z(input logic [31:0] d);
    return d[X0Z_MSB -: 16];
  endfunction

  // Callers cast the result down to their own accumulator width.
  function automatic logic [SEXT_W-1:0] sext16(input logic [15:0] s);
    return {{(SEXT_W-16){s[15]}}, s};
  endfunction

  function automatic bit acc_w_ok(input int acc_w, input int acc_num);
    return (acc_w >= 16 + $clog2(acc_num)) && (acc_w <= SEXT_W);
  endfunction

endpackage

// File: rtl/tc_accum_ram.sv
// Simple dual-port accumulation RAM: one write port, one registered read port.
module tc_accum_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Array write and 1-cycle read; the array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tc_pulse_accum.sv
// Per-bin, two-lane accumulation of BINS delayed samples over ACC_NUM triggered pulses,
// followed by a streamed dump of the accumulated frame.
module tc_pulse_accum
  import tc_accum_pkg::*;
#(
  parameter int  BINS    = 512,
  parameter int  ACC_NUM = 100,
  parameter int  ACC_W   = 32,
  localparam int BIN_AW  = $clog2(BINS),
  localparam int PC_W    = $clog2(ACC_NUM + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig_i,
  input  logic               tc_ready_i,
  input  logic [31:0]        tc_data_i,
  output logic               out_valid,
  output logic               out_last,
  output logic [2*ACC_W-1:0] out_data,
  output logic               busy,
  output logic [PC_W-1:0]    pulse_cnt,
  output logic               trig_missed
);

  if (!acc_w_ok(ACC_W, ACC_NUM)) begin : g_bad_acc_w
    $error("tc_pulse_accum: ACC_W too small for ACC_NUM or wider than sext16");
  end

  tc_state_e          state_q, state_d;
  logic               trig_q;
  logic [BIN_AW-1:0]  bin_q, bin_d;
  logic [PC_W-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic [31:0]        sample_q;
  logic               wr_en_q;
  logic [BIN_AW-1:0]  wr_addr_q;
  logic               out_valid_q, out_last_q, trig_missed_q;
  logic [2*ACC_W-1:0] out_data_q;

  logic               edge_s, bin_last_s, cap_s, dump_s, first_s;
  logic [BIN_AW-1:0]  rd_addr_s;
  logic [2*ACC_W-1:0] rdata_s, wdata_s;
  logic [ACC_W-1:0]   acc_x0_s, acc_x0z_s;

  assign edge_s     = trig_i & ~trig_q & tc_ready_i;
  assign bin_last_s = (bin_q == BIN_AW'(BINS - 1));
  assign first_s    = (pulse_cnt_q == {PC_W{1'b0}});

  // First pulse of a frame overwrites the bin, so stale RAM never leaks into a frame.
  assign acc_x0_s  = ACC_W'(sext16(lane_x0(sample_q)))
                   + (first_s ? {ACC_W{1'b0}} : rdata_s[2*ACC_W-1:ACC_W]);
  assign acc_x0z_s = ACC_W'(sext16(lane_x0z(sample_q)))
                   + (first_s ? {ACC_W{1'b0}} : rdata_s[ACC_W-1:0]);
  assign wdata_s   = {acc_x0_s, acc_x0z_s};

  tc_accum_ram #(
    .DEPTH (BINS),
    .AW    (BIN_AW),
    .DW    (2*ACC_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wdata_s),
    .raddr_i (rd_addr_s),
    .rdata_o (rdata_s)
  );

  // Next-state, bin counter, pulse counter and RAM read address.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    pulse_cnt_d = pulse_cnt_q;
    rd_addr_s   = {BIN_AW{1'b0}};
    cap_s       = 1'b0;
    dump_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (edge_s) begin
          state_d = ST_CAPTURE;
          bin_d   = {BIN_AW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (!tc_ready_i) begin
          state_d     = ST_IDLE;
          pulse_cnt_d = {PC_W{1'b0}};
        end else begin
          cap_s     = 1'b1;
          rd_addr_s = bin_q;
          bin_d     = bin_q + BIN_AW'(1);
          state_d   = bin_last_s ? ST_DRAIN : ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (!tc_ready_i) begin
          state_d     = ST_IDLE;
          pulse_cnt_d = {PC_W{1'b0}};
        end else if (pulse_cnt_q == PC_W'(ACC_NUM - 1)) begin
          // Prefetch bin 0 here so the first beat leaves two cycles after DRAIN.
          state_d     = ST_DUMP;
          bin_d       = {BIN_AW{1'b0}};
          pulse_cnt_d = pulse_cnt_q + PC_W'(1);
        end else begin
          state_d     = ST_IDLE;
          pulse_cnt_d = pulse_cnt_q + PC_W'(1);
        end
      end
      ST_DUMP: begin
        dump_s    = 1'b1;
        rd_addr_s = bin_q + BIN_AW'(1);
        bin_d     = bin_q + BIN_AW'(1);
        if (bin_last_s) begin
          state_d     = ST_IDLE;
          pulse_cnt_d = {PC_W{1'b0}};
        end else begin
          state_d = ST_DUMP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pulse_cnt_d = {PC_W{1'b0}};
      end
    endcase
  end

  // State, sample pipeline and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      trig_q        <= 1'b0;
      bin_q         <= {BIN_AW{1'b0}};
      pulse_cnt_q   <= {PC_W{1'b0}};
      sample_q      <= 32'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= {BIN_AW{1'b0}};
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= {(2*ACC_W){1'b0}};
      trig_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_q        <= trig_i;
      bin_q         <= bin_d;
      pulse_cnt_q   <= pulse_cnt_d;
      sample_q      <= cap_s ? tc_data_i : sample_q;
      wr_en_q       <= cap_s;
      wr_addr_q     <= bin_q;
      out_valid_q   <= dump_s;
      out_last_q    <= dump_s & bin_last_s;
      out_data_q    <= dump_s ? rdata_s : out_data_q;
      trig_missed_q <= edge_s & (state_q != ST_IDLE);
    end
  end

  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign pulse_cnt   = pulse_cnt_q;
  assign trig_missed = trig_missed_q;

endmodule

// File: tb/tb_tc_pulse_accum.sv
// Directed bench for tc_pulse_accum with BINS=8, ACC_NUM=3, ACC_W=32.
module tb_tc_pulse_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic        tc_ready;
  logic [31:0] tc_data;
  logic        out_valid, out_last, busy, trig_missed;
  logic [63:0] out_data;
  logic [1:0]  pulse_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int missed_cnt = 0;
  bit busy_seen  = 1'b0;

  logic [63:0] q_data[$];
  bit          q_last[$];
  int          q_cyc[$];

  always #5 clk = ~clk;

  tc_pulse_accum #(
    .BINS    (8),
    .ACC_NUM (3),
    .ACC_W   (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig_i      (trig),
    .tc_ready_i  (tc_ready),
    .tc_data_i   (tc_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_data    (out_data),
    .busy        (busy),
    .pulse_cnt   (pulse_cnt),
    .trig_missed (trig_missed)
  );

  // Output monitor on the inactive edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
    if (trig_missed) missed_cnt <= missed_cnt + 1;
    if (busy) busy_seen <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One trigger followed by 8 bins; bin k carries x0 = x0_0 + step*k.
  task automatic do_pulse(input logic [15:0] x0_0, input logic [15:0] step,
                          input logic [15:0] x0z, input int miss_at,
                          input int drop_at, input int rst_at, input int gap);
    trig = 1'b1;
    tick(1);
    for (int k = 0; k < 8; k++) begin
      tc_data = {16'(x0_0 + step * 16'(k)), x0z};
      trig    = (k == miss_at);
      if (k == drop_at) tc_ready = 1'b0;
      rst     = (k == rst_at) ? 1'b0 : 1'b1;
      tick(1);
    end
    trig = 1'b0;
    rst  = 1'b1;
    tick(gap);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 60 && q_data.size() < n; i++) tick(1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] b,
                             input logic [31:0] s, input logic [31:0] z);
    logic [63:0] d;
    wait_beats(8);
    tick(2);
    chk({tag, "_beats"}, 64'(q_data.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < q_data.size()) begin
        d = q_data[k];
        chk($sformatf("%s_x0_%0d", tag, k), {32'd0, d[63:32]}, {32'd0, b + s * 32'(k)});
        chk($sformatf("%s_x0z_%0d", tag, k), {32'd0, d[31:0]}, {32'd0, z});
        chk($sformatf("%s_last_%0d", tag, k), 64'(q_last[k]), 64'(k == 7));
      end
    end
    if (q_data.size() >= 8) chk({tag, "_contig"}, 64'(q_cyc[7] - q_cyc[0]), 64'd7);
    chk({tag, "_pcnt0"}, 64'(pulse_cnt), 64'd0);
    chk({tag, "_busy0"}, 64'(busy), 64'd0);
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  int m0;

  initial begin
    rst      = 1'b0;
    trig     = 1'b0;
    tc_ready = 1'b1;
    tc_data  = 32'd0;
    tick(3);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last",  64'(out_last), 64'd0);
    chk("rst_data",  out_data, 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_pcnt",  64'(pulse_cnt), 64'd0);
    chk("rst_miss",  64'(trig_missed), 64'd0);
    rst = 1'b1;
    tick(2);

    // 1: constant x0=1, x0z=-2 -> {3,-6}
    do_pulse(16'd1, 16'd0, 16'hFFFE, -1, -1, -1, 10);
    chk("t1_pcnt1", 64'(pulse_cnt), 64'd1);
    do_pulse(16'd1, 16'd0, 16'hFFFE, -1, -1, -1, 10);
    chk("t1_pcnt2", 64'(pulse_cnt), 64'd2);
    do_pulse(16'd1, 16'd0, 16'hFFFE, -1, -1, -1, 10);
    check_frame("t1", 32'd3, 32'd0, 32'hFFFF_FFFA);
    chk("t1_missed", 64'(missed_cnt), 64'd0);

    // 2: ramp x0=k, x0z=0x7FFF -> 3k, 98301
    for (int p = 0; p < 3; p++) do_pulse(16'd0, 16'd1, 16'h7FFF, -1, -1, -1, 10);
    check_frame("t2", 32'd0, 32'd3, 32'd98301);

    // 3: extra edge 4 cycles into CAPTURE of pulse 2
    m0 = missed_cnt;
    do_pulse(16'd1, 16'd0, 16'hFFFE, -1, -1, -1, 10);
    do_pulse(16'd1, 16'd0, 16'hFFFE, 4, -1, -1, 10);
    chk("t3_missed", 64'(missed_cnt - m0), 64'd1);
    chk("t3_pcnt2", 64'(pulse_cnt), 64'd2);
    do_pulse(16'd1, 16'd0, 16'hFFFE, -1, -1, -1, 10);
    check_frame("t3", 32'd3, 32'd0, 32'hFFFF_FFFA);

    // 4a: edges with tc_ready low are ignored silently
    m0 = missed_cnt;
    tc_ready  = 1'b0;
    tick(1);
    busy_seen = 1'b0;
    do_pulse(16'd1, 16'd0, 16'd1, -1, -1, -1, 4);
    do_pulse(16'd1, 16'd0, 16'd1, -1, -1, -1, 4);
    chk("t4_busy_seen", 64'(busy_seen), 64'd0);
    chk("t4_missed", 64'(missed_cnt - m0), 64'd0);
    tc_ready = 1'b1;
    tick(2);
    // 4b: ready falls mid-CAPTURE -> aborted frame, no output
    do_pulse(16'd2, 16'd0, 16'd2, -1, -1, -1, 10);
    chk("t4_pcnt1", 64'(pulse_cnt), 64'd1);
    do_pulse(16'd2, 16'd0, 16'd2, -1, 3, -1, 2);
    chk("t4_abort_busy", 64'(busy), 64'd0);
    chk("t4_abort_pcnt", 64'(pulse_cnt), 64'd0);
    tc_ready = 1'b1;
    tick(20);
    chk("t4_no_out", 64'(q_data.size()), 64'd0);

    // 5: reset during pulse 2, then 3 clean pulses of x0=5
    do_pulse(16'd7, 16'd0, 16'd9, -1, -1, -1, 10);
    do_pulse(16'd7, 16'd0, 16'd9, -1, -1, 3, 4);
    chk("t5_rst_busy",  64'(busy), 64'd0);
    chk("t5_rst_pcnt",  64'(pulse_cnt), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_data",  out_data, 64'd0);
    for (int p = 0; p < 3; p++) do_pulse(16'd5, 16'd0, 16'd0, -1, -1, -1, 10);
    check_frame("t5", 32'd15, 32'd0, 32'd0);

    // 6: most-negative samples, then an edge during DUMP
    m0 = missed_cnt;
    do_pulse(16'h8000, 16'd0, 16'h8000, -1, -1, -1, 10);
    do_pulse(16'h8000, 16'd0, 16'h8000, -1, -1, -1, 10);
    do_pulse(16'h8000, 16'd0, 16'h8000, -1, -1, -1, 2);
    chk("t6_in_dump", 64'(busy), 64'd1);
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    check_frame("t6", 32'hFFFE_8000, 32'd0, 32'hFFFE_8000);
    chk("t6_missed", 64'(missed_cnt - m0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
